// File: rtl/dm_bus_pkg.sv
// Shared definitions for the CPU_54 data-memory bus.
// Covers the access-size encodings, the responder FSM states and the default storage base address.
package dm_bus_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

  typedef enum logic [1:0] {
    BS_WORD = 2'b00,
    BS_HALF = 2'b01,
    BS_BYTE = 2'b10,
    BS_RSVD = 2'b11
  } bit_s_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RESP = 2'b01,
    ERR  = 2'b10
  } dm_state_e;

endpackage

// File: rtl/dm_responder_if.sv
// Data-memory bus between the core (master) and the responder (slave).
// Request signals flow from the core; response and error-status signals flow back.
interface dm_responder_if;
  logic        CS;
  logic        DM_R;
  logic        DM_W;
  logic [31:0] Addr;
  logic [31:0] Data_In;
  logic [1:0]  Bit_S;
  logic [31:0] Data_Out;
  logic        DM_ready;
  logic        DM_err;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;

  modport master (
    output CS, DM_R, DM_W, Addr, Data_In, Bit_S,
    input  Data_Out, DM_ready, DM_err, err_addr, err_cnt
  );

  modport slave (
    input  CS, DM_R, DM_W, Addr, Data_In, Bit_S,
    output Data_Out, DM_ready, DM_err, err_addr, err_cnt
  );
endinterface

// File: rtl/dm_lane_unit.sv
// Byte-lane steering for the data-memory responder (purely combinational).
// Store data is replicated across lanes with a lane mask; loads are shifted down and zero-extended.
module dm_lane_unit
  import dm_bus_pkg::*;
(
  input  bit_s_e      bit_s,
  input  logic [1:0]  off_lo,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    wmask = 4'b0000;
    wdata = 32'h0;
    rdata = 32'h0;
    unique case (bit_s)
      BS_WORD: begin
        wmask = 4'b1111;
        wdata = wdata_in;
        rdata = rword;
      end
      BS_HALF: begin
        wmask = 4'b0011 << {off_lo[1], 1'b0};
        wdata = {2{wdata_in[15:0]}};
        rdata = {16'h0, rword[{off_lo[1], 4'b0000} +: 16]};
      end
      BS_BYTE: begin
        wmask = 4'b0001 << off_lo;
        wdata = {4{wdata_in[7:0]}};
        rdata = {24'h0, rword[{off_lo, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Slave end of the CPU_54 data-memory bus: rebases the absolute address, checks range and alignment,
// does lane-masked writes and registered reads, and returns a one-cycle ready/error pulse.
module dm_responder
  import dm_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          DEPTH_WORDS = 512,
  parameter int          AW          = 11
) (
  input  logic           DM_clk,
  input  logic           DM_rst,
  dm_responder_if.slave  bus
);

  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0]   off;
  logic          in_range;
  logic          misaligned;
  logic          valid;
  logic          req_err;
  logic          rd_ok;
  logic          wr_ok;
  bit_s_e        bs;
  logic [AW-3:0] word_idx;
  logic [31:0]   rword;
  logic [3:0]    wmask;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  dm_state_e     state;
  dm_state_e     state_next;
  logic [31:0]   dout_q;
  logic [31:0]   err_addr_q;
  logic [7:0]    err_cnt_q;

  logic [31:0]   mem [DEPTH_WORDS];

  // Underflow below BASE_ADDR wraps to a huge offset, so one compare covers both ends.
  assign off      = bus.Addr - BASE_ADDR;
  assign in_range = off < SPAN;
  assign bs       = bit_s_e'(bus.Bit_S);
  assign word_idx = off[AW-1:2];

  always_comb begin
    misaligned = 1'b0;
    unique case (bs)
      BS_WORD: misaligned = off[1:0] != 2'b00;
      BS_HALF: misaligned = off[0];
      default: misaligned = 1'b0;
    endcase
  end

  assign valid   = bus.CS && (bus.DM_R || bus.DM_W);
  assign req_err = (bus.DM_R && bus.DM_W) || (bs == BS_RSVD) || !in_range || misaligned;
  assign rd_ok   = valid && !req_err && bus.DM_R;
  assign wr_ok   = valid && !req_err && bus.DM_W;
  assign rword   = mem[word_idx];

  dm_lane_unit u_lane (
    .bit_s    (bs),
    .off_lo   (off[1:0]),
    .wdata_in (bus.Data_In),
    .rword    (rword),
    .wmask    (wmask),
    .wdata    (wdata),
    .rdata    (rdata)
  );

  // NOTE: storage has no reset branch; clearing it would prevent mapping to a RAM macro.
  always_ff @(posedge DM_clk) begin
    if (wr_ok && !DM_rst) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask[l]) mem[word_idx][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    if (valid) state_next = req_err ? ERR : RESP;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge DM_clk or posedge DM_rst) begin
    if (DM_rst) begin
      state      <= IDLE;
      dout_q     <= 32'h0;
      err_addr_q <= 32'h0;
      err_cnt_q  <= 8'h0;
    end else begin
      state <= state_next;
      if (rd_ok) dout_q <= rdata;
      if (valid && req_err) begin
        err_addr_q <= bus.Addr;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    bus.DM_ready = 1'b0;
    bus.DM_err   = 1'b0;
    unique case (state)
      RESP: bus.DM_ready = 1'b1;
      ERR: begin
        bus.DM_ready = 1'b1;
        bus.DM_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Data_Out = dout_q;
  assign bus.err_addr = err_addr_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule
